// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered valid/ready slice; every output is a flop.
// Define SKID_BUFFER_FLUSH_EN to add the flush input that discards buffered beats.
module skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SKID_BUFFER_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              m_valid_q;
  logic              s_ready_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic s_fire;
  logic m_fire;

  // Handshake events seen by both sides this cycle.
  always_comb begin
    s_fire = s_valid & s_ready_q;
    m_fire = m_valid_q & m_ready;
  end

  // State, flags and payload registers; main drives downstream, skid
  // catches the beat accepted in the cycle a stall first appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end
`ifdef SKID_BUFFER_FLUSH_EN
    else if (flush) begin
      state_q   <= EMPTY;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end
`endif
    else begin
      unique case (state_q)
        EMPTY: begin
          if (s_fire) begin
            main_q    <= s_data;
            state_q   <= ONE;
            m_valid_q <= 1'b1;
            s_ready_q <= 1'b1;
          end
        end
        ONE: begin
          if (s_fire && m_fire) begin
            main_q <= s_data;
          end else if (s_fire) begin
            skid_q    <= s_data;
            state_q   <= FULL;
            m_valid_q <= 1'b1;
            s_ready_q <= 1'b0;
          end else if (m_fire) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (m_fire) begin
            main_q    <= skid_q;
            state_q   <= ONE;
            m_valid_q <= 1'b1;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: random and directed stimulus against a queue model.
// The model holds up to two accepted beats; the head is what m_data shows.
module tb_skid_buffer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid;
  logic         m_ready;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
`ifdef SKID_BUFFER_FLUSH_EN
  logic         flush;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] outs[$];

  skid_buffer #(.DATA_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef SKID_BUFFER_FLUSH_EN
    .flush   (flush),
`endif
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: model advances from the inputs present before the edge.
  task automatic step();
    bit sf;
    bit mf;
    bit fl;
    sf = s_valid && (q.size() < 2);
    mf = m_ready && (q.size() > 0);
    fl = reset;
`ifdef SKID_BUFFER_FLUSH_EN
    fl = fl || flush;
`endif
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (mf) outs.push_back(q.pop_front());
      if (sf) q.push_back(s_data);
    end
    #1;
    check("m_valid", {31'b0, m_valid}, (q.size() > 0) ? 1 : 0);
    check("s_ready", {31'b0, s_ready}, (q.size() < 2) ? 1 : 0);
    if (q.size() > 0) check("m_data", m_data, q[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    bit acc;

    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    m_ready = 1'b1;
`ifdef SKID_BUFFER_FLUSH_EN
    flush   = 1'b0;
`endif

    // reset held two cycles with a beat offered
    step();
    step();
    check("rst_mdata", m_data, 0);
    reset   = 1'b0;
    s_valid = 1'b0;
    step();
    step();
    check("rst_noout", outs.size(), 0);

    // streaming 1..16 with m_ready high
    outs.delete();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = i;
      step();
      check("stream_rdy", {31'b0, s_ready}, 1);
    end
    s_valid = 1'b0;
    step();
    check("stream_cnt", outs.size(), 16);
    for (int i = 0; i < outs.size(); i++) check("stream_val", outs[i], i + 1);

    // stall absorb
    step();
    outs.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA0;
    step();
    check("stall_a0", m_data, 32'hA0);
    s_data  = 32'hA1;
    step();
    check("stall_full", {31'b0, s_ready}, 0);
    check("stall_hold", m_data, 32'hA0);
    s_data  = 32'hA2;
    step();
    step();
    check("stall_hold2", m_data, 32'hA0);
    m_ready = 1'b1;
    step();
    step();
    s_valid = 1'b0;
    step();
    step();
    check("stall_cnt", outs.size(), 3);
    if (outs.size() == 3) begin
      check("stall_o0", outs[0], 32'hA0);
      check("stall_o1", outs[1], 32'hA1);
      check("stall_o2", outs[2], 32'hA2);
    end

    // random backpressure, 1000 incrementing beats
    outs.delete();
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      s_valid = $urandom_range(0, 1);
      s_data  = sent;
      m_ready = ($urandom_range(0, 3) != 0);
      acc = s_valid && (q.size() < 2);
      step();
      if (acc) sent++;
      cyc++;
    end
    check("rnd_sent", sent, 1000);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rnd_cnt", outs.size(), 1000);
    for (int i = 0; i < outs.size(); i++) begin
      if (outs[i] !== i) begin
        check("rnd_order", outs[i], i);
        break;
      end
    end

    // reset from FULL
    outs.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hB0;
    step();
    s_data  = 32'hB1;
    step();
    check("rf_full", {31'b0, s_ready}, 0);
    reset   = 1'b1;
    s_data  = 32'hB2;
    step();
    check("rf_empty", {31'b0, m_valid}, 0);
    reset   = 1'b0;
    m_ready = 1'b1;
    s_data  = 32'hC0;
    step();
    s_valid = 1'b0;
    step();
    step();
    check("rf_cnt", outs.size(), 1);
    if (outs.size() > 0) check("rf_first", outs[0], 32'hC0);

`ifdef SKID_BUFFER_FLUSH_EN
    // flush with 0xE0/0xE1 buffered and 0xE2 offered
    outs.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hE0;
    step();
    s_data  = 32'hE1;
    step();
    flush   = 1'b1;
    s_data  = 32'hE2;
    step();
    check("fl_mvalid", {31'b0, m_valid}, 0);
    check("fl_sready", {31'b0, s_ready}, 1);
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("fl_noout", outs.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_buffer.md
# skid_buffer

Two-entry registered pipeline slice with valid/ready handshakes on both sides. It is the flow-controlled counterpart of the team's plain enable flop. The plain flop only captures when `en` is high. This block also releases stored data downstream and holds it until the consumer takes it. It cuts every combinational path (data, valid and ready) between the cache request/response stages while sustaining one transfer per cycle.

## Interface
Parameters:
- `DATA_W`, default 32: payload width in bits.

Ports:
- `clk`, input, 1: clock. All state updates occur on its rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `s_valid`, input, 1: upstream has a beat on `s_data`.
- `s_ready`, output, 1: buffer can accept a beat this cycle. Driven directly from a flop.
- `s_data`, input, `DATA_W`: upstream payload.
- `m_valid`, output, 1: a beat is presented on `m_data`. Driven directly from a flop.
- `m_ready`, input, 1: downstream accepts the beat.
- `m_data`, output, `DATA_W`: downstream payload. Driven directly from a flop.
- `flush`, input, 1: discard all buffered beats. Present only with `SKID_BUFFER_FLUSH_EN` defined.

## Operation
- Storage: an output register (`main`) drives `m_data`. A `skid` register catches the beat accepted in the cycle a stall first appears.
- Transfer events:
  - s_fire = `s_valid & s_ready`
  - m_fire = `m_valid & m_ready`
- States:
  - EMPTY: `m_valid`=0, `s_ready`=1.
  - ONE: `m_valid`=1, `s_ready`=1.
  - FULL: `m_valid`=1, `s_ready`=0.
- Transitions from EMPTY:
  - s_fire: `main`<=`s_data`, go to ONE.
  - otherwise: stay in EMPTY.
- Transitions from ONE:
  - s_fire and m_fire: `main`<=`s_data`, stay in ONE.
  - s_fire and no m_fire: `skid`<=`s_data`, go to FULL.
  - m_fire and no s_fire: go to EMPTY.
  - neither: hold.
- Transitions from FULL:
  - m_fire: `main`<=`skid`, go to ONE.
  - otherwise: hold.
  - No upstream beat can be accepted, because `s_ready`=0.
- Ordering: strict FIFO. No beat is ever dropped or duplicated outside reset or flush.
- Stability: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` remain constant.
- `s_valid` deasserting without a transfer has no effect. The block places no stability requirement on the upstream.
- Unused register contents are don't-care. Data registers are never required to clear, except as stated under reset.

## Timing
- Reset: in any cycle with `reset`=1, the next state is EMPTY regardless of other inputs. Any beat that would have transferred in that cycle is lost.
- Values after the reset edge: `m_valid`=0, `s_ready`=1, `m_data`=0.
- Reset mid-operation, in ONE or FULL: all buffered beats are discarded in the same way.
- Latency: a beat accepted at edge N appears on `m_data` with `m_valid`=1 after edge N. `m_data` cannot be consumed before edge N+1.
- Throughput: one beat per cycle in steady state with `m_ready` held high. The buffer never enters FULL in that case.
- Stall response: `s_ready` falls exactly one edge after the first stalled cycle in which a beat was accepted. At most one extra beat is absorbed, in the skid register.
- Stall release: `s_ready` rises one edge after the m_fire that empties the skid register.
- Combinational paths: none from any input to any output.

## Configuration
- `SKID_BUFFER_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 with `reset`=0 forces the next state to EMPTY, so `m_valid`=0 and `s_ready`=1 after the edge.
  - Flush has priority over every transfer in that cycle. An s_fire coincident with flush is discarded. The upstream regards it as sent.
  - Data registers are left unchanged. `reset` has priority over `flush`.
- `SKID_BUFFER_FLUSH_EN` undefined: no `flush` port and no flush logic. All other behaviour is identical.

## Test plan
- Reset check: hold `reset` 2 cycles with `s_valid`=1 and `s_data`=0xDEAD. Required: after release, `m_valid`=0, `s_ready`=1, `m_data`=0, and no beat emerges.
- Streaming: send 0x1..0x10 back-to-back with `m_ready`=1. Required: the same sequence is output with 1-cycle latency, `s_ready` never falls, and throughput is 16 beats in 16 cycles.
- Stall absorb: stream 0xA0, 0xA1, 0xA2 with `m_ready`=0 from the cycle 0xA0 is presented. Required:
  - 0xA0 is held on `m_data`, 0xA1 goes into the skid register, and `s_ready` is 0 after the second accept.
  - 0xA2 is held upstream.
  - Raising `m_ready` yields 0xA0, 0xA1, 0xA2 in order.
- Random backpressure: drive 1000 beats of incrementing data with random `s_valid`/`m_ready`. Required: the output sequence is identical to the input, `m_data` is stable during every stall, and nothing is lost or duplicated.
- Reset from FULL: with 0xB0/0xB1 buffered, assert `reset` for 1 cycle. Required: EMPTY afterwards, and the next input 0xC0 is the first output.
- Flush (macro on): with 0xE0/0xE1 buffered, assert `flush` together with `s_valid`=1 and 0xE2. Required: `m_valid`=0 and `s_ready`=1 next cycle, and none of 0xE0–0xE2 is ever output.
